// File: rtl/rib_bus.sv
// RIB interconnect: fixed-priority arbitration of two masters onto four decoded
// slaves, with a per-access wait timeout and the core's rib_hold_flag stall.
module rib_bus #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_sel,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m0_wdata,
  output logic [ADDR_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_sel,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [ADDR_W-1:0] m1_wdata,
  output logic [ADDR_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              rib_hold_flag,
  output logic              bus_err,
  output logic [3:0]        s_req,
  output logic              s_we,
  output logic [3:0]        s_sel,
  output logic [ADDR_W-1:0] s_addr,
  output logic [ADDR_W-1:0] s_wdata,
  input  logic [ADDR_W-1:0] s_rdata0,
  input  logic [ADDR_W-1:0] s_rdata1,
  input  logic [ADDR_W-1:0] s_rdata2,
  input  logic [ADDR_W-1:0] s_rdata3,
  input  logic [3:0]        s_ack
);

  localparam int unsigned NSLV  = 4;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned RGN_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              r_state, w_state;
  logic                r_owner, w_owner;
  logic [NSLV-1:0]     r_req, w_req;
  logic                r_we, w_we;
  logic [SEL_W-1:0]    r_sel, w_sel;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [ADDR_W-1:0]   r_wdata, w_wdata;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [ADDR_W-1:0]   r_rdata0, w_rdata0;
  logic [ADDR_W-1:0]   r_rdata1, w_rdata1;
  logic                r_ack0, w_ack0;
  logic                r_ack1, w_ack1;
  logic                r_err, w_err;

  logic [RGN_W-1:0]    w_rgn;
  logic [ADDR_W-1:0]   w_srdata;
  logic                w_fin;
  logic                w_fin_err;
  logic                w_fin_load;
  logic [ADDR_W-1:0]   w_fin_data;

  // Read data of the slave currently being accessed
  always_comb begin
    w_srdata = '0;
    case (r_req)
      4'b0001: w_srdata = s_rdata0;
      4'b0010: w_srdata = s_rdata1;
      4'b0100: w_srdata = s_rdata2;
      4'b1000: w_srdata = s_rdata3;
      default: w_srdata = '0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state    = r_state;
    w_owner    = r_owner;
    w_req      = r_req;
    w_we       = r_we;
    w_sel      = r_sel;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_cnt      = r_cnt;
    w_rdata0   = r_rdata0;
    w_rdata1   = r_rdata1;
    w_ack0     = 1'b0;
    w_ack1     = 1'b0;
    w_err      = 1'b0;
    w_fin      = 1'b0;
    w_fin_err  = 1'b0;
    w_fin_load = 1'b0;
    w_fin_data = '0;
    w_rgn      = m0_req ? m0_addr[ADDR_W-1 -: RGN_W] : m1_addr[ADDR_W-1 -: RGN_W];

    case (r_state)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          w_owner = ~m0_req;
          w_we    = m0_req ? m0_we    : m1_we;
          w_sel   = m0_req ? m0_sel   : m1_sel;
          w_addr  = m0_req ? m0_addr  : m1_addr;
          w_wdata = m0_req ? m0_wdata : m1_wdata;
          w_cnt   = '0;
          if (w_rgn < RGN_W'(NSLV)) begin
            w_req   = NSLV'(1) << w_rgn;
            w_state = S_WAIT;
          end else begin
            w_fin      = 1'b1;
            w_fin_err  = 1'b1;
            w_fin_load = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (|(s_ack & r_req)) begin
          w_fin      = 1'b1;
          w_fin_load = ~r_we;
          w_fin_data = w_srdata;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_fin      = 1'b1;
          w_fin_err  = 1'b1;
          w_fin_load = 1'b1;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    // Completion: release the slave, pulse the owner's ack, update its read data
    if (w_fin) begin
      w_state = S_DONE;
      w_req   = '0;
      w_err   = w_fin_err;
      w_ack0  = ~w_owner;
      w_ack1  = w_owner;
      if (w_fin_load) begin
        if (w_owner) w_rdata1 = w_fin_data;
        else         w_rdata0 = w_fin_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_req    <= '0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_owner  <= w_owner;
      r_req    <= w_req;
      r_we     <= w_we;
      r_sel    <= w_sel;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_cnt    <= w_cnt;
      r_rdata0 <= w_rdata0;
      r_rdata1 <= w_rdata1;
      r_ack0   <= w_ack0;
      r_ack1   <= w_ack1;
      r_err    <= w_err;
    end
  end

  assign s_req    = r_req;
  assign s_we     = r_we;
  assign s_sel    = r_sel;
  assign s_addr   = r_addr;
  assign s_wdata  = r_wdata;
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;
  assign m0_ack   = r_ack0;
  assign m1_ack   = r_ack1;
  assign bus_err  = r_err;

  // Stall drops in the core's ack cycle so it advances with valid read data
  assign rib_hold_flag = m1_req & ~r_ack1;

endmodule

// File: tb/tb_rib_bus.sv
// Randomized scoreboard bench for rib_bus with a behavioural slave set whose
// wait time is derived from the address (addr[27] set means the slave never acks).
module tb_rib_bus;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [3:0]  m0_sel = '0, m1_sel = '0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        m0_ack, m1_ack, rib_hold_flag, bus_err, s_we;
  logic [3:0]  s_req, s_sel, s_ack;
  logic [31:0] s_rd [4];

  rib_bus #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .rib_hold_flag(rib_hold_flag), .bus_err(bus_err),
    .s_req(s_req), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata0(s_rd[0]), .s_rdata1(s_rd[1]), .s_rdata2(s_rd[2]), .s_rdata3(s_rd[3]),
    .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        q0[$], q1[$];
  exp_t        e_mon;
  logic [31:0] model_rd [2];
  logic        cur_v [2];
  logic        cur_we [2];
  logic [3:0]  cur_sel [2];
  logic [31:0] cur_addr [2];
  logic [31:0] cur_wd [2];
  int          npass = 0, ntotal = 0, cyc = 0, g_m = 0;
  logic [3:0]  p_req = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sdata(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C ^ {a[15:0], a[31:16]};
  endfunction

  function automatic int slv_lat(input logic [31:0] a);
    return a[27] ? 1000 : int'(a[5:2]);
  endfunction

  // Cycles from request assertion (DUT idle) to the ack cycle
  function automatic int auto_lat(input logic [31:0] a);
    if (a[31:28] > 4'd3) return 1;
    if (slv_lat(a) >= int'(TO)) return int'(TO) + 1;
    return 2 + slv_lat(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Issue one transfer from master m and hold req until its ack
  task automatic txn(input int m, input logic we, input logic [3:0] sel,
                     input logic [31:0] addr, input logic [31:0] wdata, input int lat);
    exp_t e;
    bit   got;
    got   = 1'b0;
    e.lat = lat;
    e.t0  = cyc;
    if (addr[31:28] > 4'd3 || slv_lat(addr) >= int'(TO)) begin
      e.err = 1'b1;
      model_rd[m] = '0;
    end else begin
      e.err = 1'b0;
      if (!we) model_rd[m] = sdata(addr);
    end
    e.rdata = model_rd[m];
    if (m == 0) q0.push_back(e); else q1.push_back(e);
    cur_we[m] = we; cur_sel[m] = sel; cur_addr[m] = addr; cur_wd[m] = wdata; cur_v[m] = 1'b1;
    if (m == 0) begin
      m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      ntotal++;
      $display("FAIL ack_wait m%0d: no ack within 100 cycles, expected an ack", m);
      if (m == 0 && q0.size() > 0) void'(q0.pop_back());
      if (m == 1 && q1.size() > 0) void'(q1.pop_back());
    end
    @(posedge clk); #1;
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    cur_v[m] = 1'b0;
  endtask

  task automatic rnd_txn(input int m);
    logic [31:0] a;
    int          r;
    a = $urandom;
    r = $urandom_range(0, 5);
    a[31:28] = (r == 4) ? 4'h9 : (r == 5) ? 4'hF : 4'(r);
    a[27]    = ($urandom_range(0, 7) == 0);
    txn(m, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, -1);
  endtask

  // Slave set: the addressed slave acks after slv_lat(addr) wait cycles; the
  // others toggle stray acks and junk read data that the bus must ignore.
  initial begin
    int wcnt;
    bit ackg;
    wcnt  = 0;
    s_ack = '0;
    for (int i = 0; i < 4; i++) s_rd[i] = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst || s_req == 4'b0) begin
        wcnt = 0;
        ackg = 1'b0;
      end else begin
        ackg = (wcnt == slv_lat(s_addr));
        wcnt++;
      end
      s_ack = (ackg ? s_req : 4'b0) | (4'($urandom) & ~s_req);
      for (int i = 0; i < 4; i++) begin
        s_rd[i] = $urandom;
        if (ackg && s_req[i]) s_rd[i] = sdata(s_addr);
      end
    end
  end

  // Monitor: master completions against the scoreboard, slave-side bus, stall flag
  always @(negedge clk) begin
    if (rst) begin
      if (m0_ack) begin
        if (q0.size() == 0) begin
          ntotal++;
          $display("FAIL m0_ack: got unexpected ack, expected none");
        end else begin
          e_mon = q0.pop_front();
          chk("m0_rdata", m0_rdata, e_mon.rdata);
          chk("m0_bus_err", 32'(bus_err), 32'(e_mon.err));
          if (e_mon.lat >= 0) chk("m0_latency", 32'(cyc - e_mon.t0), 32'(e_mon.lat));
        end
      end
      if (m1_ack) begin
        if (q1.size() == 0) begin
          ntotal++;
          $display("FAIL m1_ack: got unexpected ack, expected none");
        end else begin
          e_mon = q1.pop_front();
          chk("m1_rdata", m1_rdata, e_mon.rdata);
          chk("m1_bus_err", 32'(bus_err), 32'(e_mon.err));
          if (e_mon.lat >= 0) chk("m1_latency", 32'(cyc - e_mon.t0), 32'(e_mon.lat));
        end
      end
      if (bus_err && !m0_ack && !m1_ack)
        chk("bus_err_without_ack", 32'(bus_err), 32'(0));
      chk("hold_flag", 32'(rib_hold_flag), 32'(m1_req & ~m1_ack));
      if (s_req != 4'b0) begin
        if (p_req == 4'b0) begin
          g_m = (cur_v[0] && s_addr == cur_addr[0] && s_we == cur_we[0] &&
                 s_sel == cur_sel[0] && s_wdata == cur_wd[0]) ? 0 : 1;
          chk("grant_has_request", 32'(cur_v[g_m]), 32'(1));
        end
        chk("s_addr", s_addr, cur_addr[g_m]);
        chk("s_wdata", s_wdata, cur_wd[g_m]);
        chk("s_we_sel", 32'({s_we, s_sel}), 32'({cur_we[g_m], cur_sel[g_m]}));
        chk("s_req_decode", 32'(s_req),
            (cur_addr[g_m][31:28] < 4'd4) ? 32'(1) << cur_addr[g_m][31:28] : 32'(0));
      end
    end
    p_req = rst ? s_req : 4'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      model_rd[i] = '0; cur_v[i] = 1'b0; cur_we[i] = 1'b0;
      cur_sel[i] = '0; cur_addr[i] = '0; cur_wd[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_s_req", 32'(s_req), 32'(0));
    chk("rst_s_addr", s_addr, 32'(0));
    chk("rst_s_wdata", s_wdata, 32'(0));
    chk("rst_s_ctl", 32'({s_we, s_sel}), 32'(0));
    chk("rst_rdata", m0_rdata | m1_rdata, 32'(0));
    chk("rst_ack_err", 32'({m0_ack, m1_ack, bus_err, rib_hold_flag}), 32'(0));

    // Directed core accesses with exact latency
    txn(1, 1'b0, 4'hF, 32'h1000_0010, 32'h0, auto_lat(32'h1000_0010));
    txn(1, 1'b0, 4'hF, 32'h1000_0000, 32'h0, auto_lat(32'h1000_0000));
    txn(1, 1'b0, 4'hF, 32'h0000_003C, 32'h0, auto_lat(32'h0000_003C));
    txn(1, 1'b0, 4'hF, 32'h3800_0000, 32'h0, auto_lat(32'h3800_0000));
    txn(1, 1'b0, 4'hF, 32'h8000_0000, 32'h0, auto_lat(32'h8000_0000));
    txn(1, 1'b0, 4'hF, 32'h2000_0008, 32'h0, auto_lat(32'h2000_0008));
    txn(1, 1'b0, 4'hF, 32'h1000_0020, 32'h0, auto_lat(32'h1000_0020));
    txn(1, 1'b1, 4'b0011, 32'h1000_0024, 32'h5555_5555, auto_lat(32'h1000_0024));
    txn(0, 1'b0, 4'hF, 32'h3000_0004, 32'h0, auto_lat(32'h3000_0004));

    // Simultaneous requests: m0 first, m1 in the idle cycle after m0's done
    fork
      txn(0, 1'b1, 4'hF, 32'h0000_0004, 32'h1234_5678, 3);
      txn(1, 1'b0, 4'hF, 32'h1000_0000, 32'h0, 6);
    join

    // Reset two cycles into a timer access that would otherwise time out
    cur_we[1] = 1'b0; cur_sel[1] = 4'hF; cur_addr[1] = 32'h2800_0000; cur_wd[1] = 32'h0;
    cur_v[1] = 1'b1;
    m1_we = 1'b0; m1_sel = 4'hF; m1_addr = 32'h2800_0000; m1_wdata = 32'h0; m1_req = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_s_req", 32'(s_req), 32'(0));
    chk("midrst_s_bus", s_addr | s_wdata, 32'(0));
    chk("midrst_rdata", m0_rdata | m1_rdata, 32'(0));
    chk("midrst_ack_err", 32'({m0_ack, m1_ack, bus_err, s_we, s_sel}), 32'(0));
    m1_req = 1'b0;
    cur_v[1] = 1'b0;
    model_rd[0] = '0;
    model_rd[1] = '0;
    @(negedge clk) rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    txn(1, 1'b0, 4'hF, 32'h1000_0010, 32'h0, auto_lat(32'h1000_0010));

    // Random contention between both masters
    fork
      for (int i = 0; i < 30; i++) begin
        rnd_txn(0);
        repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
      end
      for (int j = 0; j < 40; j++) begin
        rnd_txn(1);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    join

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'(0));
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
